// File: rtl/quant_sched_pkg.sv
// Shared definitions for the quantizer scheduler and the quantizer instantiation site.
package quant_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } sched_st_e;

  localparam int QUANT_LAT_DEF = 5;
  localparam int ARR_IDATA_BIT = 8;
  localparam int ARR_ODATA_BIT = 16;

endpackage

// File: rtl/quant_sched_if.sv
// Scheduler <-> core_quant bus: config registers, issue strobe and returning result.
interface quant_sched_if #(
  parameter int IDATA_BIT = 16,
  parameter int ODATA_BIT = 8
);
  logic [IDATA_BIT-1:0] quant_cfg_scale;
  logic [IDATA_BIT-1:0] quant_cfg_bias;
  logic [IDATA_BIT-1:0] quant_cfg_shift;
  logic [IDATA_BIT-1:0] quant_idata;
  logic                 quant_idata_valid;
  logic [ODATA_BIT-1:0] quant_odata;
  logic                 quant_odata_valid;

  modport master (
    output quant_cfg_scale, quant_cfg_bias, quant_cfg_shift, quant_idata, quant_idata_valid,
    input  quant_odata, quant_odata_valid
  );
  modport slave (
    input  quant_cfg_scale, quant_cfg_bias, quant_cfg_shift, quant_idata, quant_idata_valid,
    output quant_odata, quant_odata_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_LANE = 4,
  parameter int LANE_BIT = $clog2(NUM_LANE)
) (
  input  logic                en,
  input  logic [NUM_LANE-1:0] req,
  input  logic [LANE_BIT-1:0] ptr,
  output logic [NUM_LANE-1:0] gnt,
  output logic [LANE_BIT-1:0] gnt_idx
);
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    // Scan from the farthest lane back so the lane nearest ptr overwrites last.
    for (int k = NUM_LANE-1; k >= 0; k--) begin
      if (en && req[(int'(ptr) + k) % NUM_LANE]) begin
        gnt = '0;
        gnt[(int'(ptr) + k) % NUM_LANE] = 1'b1;
        gnt_idx = LANE_BIT'((int'(ptr) + k) % NUM_LANE);
      end
    end
  end
endmodule

// File: rtl/quant_sched.sv
// Arbitrates NUM_LANE accumulator lanes onto one shared quantizer, tags each sample
// with its source lane, and applies config updates only once the quantizer is empty.
module quant_sched
  import quant_sched_pkg::*;
#(
  parameter int NUM_LANE  = 4,
  parameter int IDATA_BIT = ARR_ODATA_BIT,
  parameter int ODATA_BIT = ARR_IDATA_BIT,
  parameter int QUANT_LAT = QUANT_LAT_DEF,
  parameter int LANE_BIT  = $clog2(NUM_LANE)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_LANE*IDATA_BIT-1:0] lane_idata,
  input  logic [NUM_LANE-1:0]           lane_idata_valid,
  output logic [NUM_LANE-1:0]           lane_idata_ready,
  input  logic                          cfg_upd_valid,
  input  logic [IDATA_BIT-1:0]          cfg_upd_scale,
  input  logic [IDATA_BIT-1:0]          cfg_upd_bias,
  input  logic [IDATA_BIT-1:0]          cfg_upd_shift,
  output logic                          cfg_upd_ready,
  quant_sched_if.master                 qif,
  output logic [NUM_LANE*ODATA_BIT-1:0] lane_odata,
  output logic [NUM_LANE-1:0]           lane_odata_valid,
  output logic                          busy,
  output logic                          err_tag
);
  localparam int CNT_BIT = $clog2(QUANT_LAT + 2);

  sched_st_e                           st;
  logic [LANE_BIT-1:0]                 rr_ptr, gnt_idx, iss_lane;
  logic [CNT_BIT-1:0]                  inflight;
  logic [QUANT_LAT-1:0]                tag_vld;
  logic [QUANT_LAT-1:0][LANE_BIT-1:0]  tag_lane;
  logic                                grant_en, xfer, tail_vld;
  logic [LANE_BIT-1:0]                 tail_lane;

  assign grant_en  = (st == ST_RUN) && !cfg_upd_valid;
  assign xfer      = |(lane_idata_valid & lane_idata_ready);
  assign tail_vld  = tag_vld[QUANT_LAT-1];
  assign tail_lane = tag_lane[QUANT_LAT-1];
  assign busy      = (inflight != '0) || (st != ST_RUN);

  rr_arbiter #(.NUM_LANE(NUM_LANE), .LANE_BIT(LANE_BIT)) u_arb (
    .en      (grant_en),
    .req     (lane_idata_valid),
    .ptr     (rr_ptr),
    .gnt     (lane_idata_ready),
    .gnt_idx (gnt_idx)
  );

  // Config FSM: drain must also see an empty issue stage before loading.
  always_ff @(posedge clk) begin
    if (rst) begin
      st                  <= ST_RUN;
      cfg_upd_ready       <= 1'b0;
      qif.quant_cfg_scale <= '0;
      qif.quant_cfg_bias  <= '0;
      qif.quant_cfg_shift <= '0;
    end else begin
      cfg_upd_ready <= 1'b0;
      case (st)
        ST_RUN:   if (cfg_upd_valid) st <= ST_DRAIN;
        ST_DRAIN: if (inflight == '0 && !qif.quant_idata_valid) begin
          st            <= ST_LOAD;
          cfg_upd_ready <= 1'b1;
        end
        ST_LOAD: begin
          qif.quant_cfg_scale <= cfg_upd_scale;
          qif.quant_cfg_bias  <= cfg_upd_bias;
          qif.quant_cfg_shift <= cfg_upd_shift;
          st                  <= ST_RUN;
        end
        default:  st <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr                <= '0;
      qif.quant_idata       <= '0;
      qif.quant_idata_valid <= 1'b0;
      iss_lane              <= '0;
    end else begin
      qif.quant_idata_valid <= xfer;
      if (xfer) begin
        qif.quant_idata <= lane_idata[gnt_idx*IDATA_BIT +: IDATA_BIT];
        iss_lane        <= gnt_idx;
        rr_ptr          <= (gnt_idx == LANE_BIT'(NUM_LANE-1)) ? '0 : gnt_idx + LANE_BIT'(1);
      end
    end
  end

  // Tag pipe tail lines up with quant_odata_valid for the same sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld  <= '0;
      tag_lane <= '0;
      inflight <= '0;
    end else begin
      tag_vld[0]  <= qif.quant_idata_valid;
      tag_lane[0] <= iss_lane;
      for (int i = 1; i < QUANT_LAT; i++) begin
        tag_vld[i]  <= tag_vld[i-1];
        tag_lane[i] <= tag_lane[i-1];
      end
      case ({qif.quant_idata_valid, tail_vld})
        2'b10:   inflight <= inflight + CNT_BIT'(1);
        2'b01:   inflight <= inflight - CNT_BIT'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_odata       <= '0;
      lane_odata_valid <= '0;
      err_tag          <= 1'b0;
    end else begin
      lane_odata_valid <= '0;
      if (qif.quant_odata_valid && tail_vld) begin
        lane_odata[tail_lane*ODATA_BIT +: ODATA_BIT] <= qif.quant_odata;
        lane_odata_valid[tail_lane]                  <= 1'b1;
      end
      if (qif.quant_odata_valid != tail_vld) err_tag <= 1'b1;
    end
  end
endmodule
